// File: rtl/fp_pkg.sv
// Shared binary32 definitions and the accumulator state encoding.
package fp_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int FP_W   = SIGN_W + EXP_W + MAN_W;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/fsum_ieee754_if.sv
// Job/operand/result handshake bundle for the stream accumulator.
interface fsum_ieee754_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fadd_ieee754.sv
// Combinational binary32 adder: round-to-nearest-even, gradual underflow,
// single canonical quiet NaN, exact-zero sums are +0 unless both inputs are -0.
module fadd_ieee754
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] out
);

    logic             sa, sb, a_nan, b_nan, a_inf, b_inf;
    logic [EXP_W-1:0] ea, eb, x1, x2, d;
    logic [MAN_W-1:0] fa, fb;
    logic             s1, s2, sticky, rnd_up, rsign;
    logic [MAN_W:0]   m1, m2;
    logic [4:0]       dc, lz, sh;
    logic [MAN_W+3:0] m1e, m2e, m2s, n;
    logic [MAN_W+4:0] r;
    logic [EXP_W+1:0] e_n, e_f;
    logic [MAN_W+1:0] m_r;

    // Align the smaller operand (guard/round/sticky), add, normalise, round.
    always_comb begin
        sa = a[FP_W-1];  ea = a[FP_W-2:MAN_W];  fa = a[MAN_W-1:0];
        sb = b[FP_W-1];  eb = b[FP_W-2:MAN_W];  fb = b[MAN_W-1:0];
        a_nan = (ea == '1) && (fa != '0);
        b_nan = (eb == '1) && (fb != '0);
        a_inf = (ea == '1) && (fa == '0);
        b_inf = (eb == '1) && (fb == '0);

        // Larger magnitude goes first; subnormals use effective exponent 1.
        if (b[FP_W-2:0] > a[FP_W-2:0]) begin
            s1 = sb; x1 = (eb == '0) ? 8'd1 : eb; m1 = {eb != '0, fb};
            s2 = sa; x2 = (ea == '0) ? 8'd1 : ea; m2 = {ea != '0, fa};
        end else begin
            s1 = sa; x1 = (ea == '0) ? 8'd1 : ea; m1 = {ea != '0, fa};
            s2 = sb; x2 = (eb == '0) ? 8'd1 : eb; m2 = {eb != '0, fb};
        end

        d   = x1 - x2;
        dc  = (d > 8'd27) ? 5'd27 : d[4:0];
        m1e = {m1, 3'b000};
        m2e = {m2, 3'b000};
        m2s = m2e >> dc;
        sticky = 1'b0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (i < 32'(dc) && m2e[i]) sticky = 1'b1;
        end
        m2s[0] = m2s[0] | sticky;

        r = (s1 == s2) ? ({1'b0, m1e} + {1'b0, m2s}) : ({1'b0, m1e} - {1'b0, m2s});

        lz = 5'd27;
        for (int unsigned i = 0; i < 27; i++) begin
            if (r[i]) lz = 5'(26 - i);
        end
        // Left shift may not take the exponent below 1 (subnormal result).
        sh = ({3'b000, lz} > (x1 - 8'd1)) ? 5'(x1 - 8'd1) : lz;

        if (r[MAN_W+4]) begin
            n   = {r[MAN_W+4:2], r[1] | r[0]};
            e_n = {2'b00, x1} + 10'd1;
        end else begin
            n   = r[MAN_W+3:0] << sh;
            e_n = {2'b00, x1} - {5'b00000, sh};
        end

        rnd_up = n[2] & (n[1] | n[0] | n[3]);
        m_r    = {1'b0, n[MAN_W+3:3]} + 25'(rnd_up);
        if (m_r[MAN_W+1])    e_f = e_n + 10'd1;
        else if (m_r[MAN_W]) e_f = e_n;
        else                 e_f = '0;

        rsign = (r == '0) ? (s1 & s2) : s1;
        if (r == '0)
            out = {rsign, 31'b0};
        else if (e_f >= 10'd255)
            out = {rsign, 8'hFF, 23'b0};
        else
            out = {rsign, e_f[EXP_W-1:0], m_r[MAN_W+1] ? 23'b0 : m_r[MAN_W-1:0]};

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            out = FP_QNAN;
        else if (a_inf)
            out = a;
        else if (b_inf)
            out = b;
    end

endmodule

// File: rtl/fsum_ieee754.sv
// Stream accumulator: sums a job of len binary32 operands through fadd_ieee754
// and emits the total as a single out_valid beat.
module fsum_ieee754
    import fp_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    fsum_ieee754_if.slave      bus
);

    state_t           state, state_nxt;
    logic [FP_W-1:0]  acc, sum;
    logic [LEN_W-1:0] remaining;
    logic             first;
    logic             in_ready, out_valid, busy, beat;

    fadd_ieee754 u_fadd (
        .a   (acc),
        .b   (bus.in_data),
        .out (sum)
    );

    assign beat          = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_data  = acc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) state_nxt = (bus.len != '0) ? ACC : DONE;
            end
            ACC: begin
                in_ready = 1'b1;
                if (beat && remaining == LEN_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, beat down-counter and first-beat flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= FP_ZERO;
            remaining <= '0;
            first     <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                remaining <= bus.len;
                first     <= 1'b1;
                if (bus.len == '0) acc <= FP_ZERO;
            end else if (beat) begin
                acc       <= first ? bus.in_data : sum;
                first     <= 1'b0;
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fsum_ieee754.sv
// Bench for fsum_ieee754: exact-arithmetic reference adder, expected-result
// queue keyed by the cycle each result must appear, per-cycle output compare.
module tb_fsum_ieee754;

    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fsum_ieee754_if #(.LEN_W(LEN_W)) bus ();

    fsum_ieee754 #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned at;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ops [0:255];
    logic [31:0] exp_hold = 32'h0;
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          pulses = 0;
    int          jobs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    // Binary32 value as an exact integer in units of 2^-149.
    function automatic logic signed [299:0] to_fixed(input logic [31:0] x);
        logic [299:0] mag;
        mag = '0;
        if (x[30:23] == 8'd0) begin
            mag[22:0] = x[22:0];
        end else begin
            mag[23:0] = {1'b1, x[22:0]};
            mag = mag << (x[30:23] - 1);
        end
        return x[31] ? -$signed(mag) : $signed(mag);
    endfunction

    // Reference add: exact sum, then one round-to-nearest-even to binary32.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        logic signed [299:0] v;
        logic [299:0] m, q, rem, half;
        logic a_nan, b_nan, a_inf, b_inf, sgn;
        int p, sh, fld;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return 32'h7FC0_0000;
        if (a_inf) return a;
        if (b_inf) return b;
        v = to_fixed(a) + to_fixed(b);
        if (v == 0) return {a[31] & b[31], 31'b0};
        sgn = (v < 0);
        m = sgn ? -v : v;
        p = 0;
        for (int i = 0; i < 300; i++) if (m[i]) p = i;
        if (p <= 22) return {sgn, 8'h00, m[22:0]};
        sh = p - 23;
        q = m >> sh;
        rem = m - (q << sh);
        if (sh > 0) begin
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q[24]) begin
            q = q >> 1;
            sh++;
        end
        fld = sh + 1;
        if (fld >= 255) return {sgn, 8'hFF, 23'h0};
        return {sgn, 8'(fld), q[22:0]};
    endfunction

    function automatic logic [31:0] ref_sum(input int n);
        logic [31:0] s;
        if (n == 0) return 32'h0;
        s = ops[0];
        for (int i = 1; i < n; i++) s = model_add(s, ops[i]);
        return s;
    endfunction

    function automatic logic [31:0] rnd_fp(input logic [31:0] prev);
        logic [31:0] v;
        v = {$urandom_range(0, 1) == 1, 8'($urandom_range(110, 150)), 23'($urandom)};
        case ($urandom_range(0, 9))
            0: v = $urandom;
            1: v = {v[31], 31'b0};
            2: v = {v[31], 8'h00, v[22:0]};
            3: v = {~prev[31], prev[30:0]};
            default: ;
        endcase
        return v;
    endfunction

    // Per-cycle output check against the expected-result queue.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_data", bus.out_data, exp_q[0].val);
            exp_hold = exp_q[0].val;
            exp_q.pop_front();
        end else begin
            chk("out_valid", 32'(bus.out_valid), 32'd0);
            if (!bus.busy) chk("out_data_hold", bus.out_data, exp_hold);
        end
        if (bus.out_valid) pulses++;
    end

    // Starts at a negedge with the DUT idle; returns at the negedge it is idle again.
    task automatic run_job(input int n, input int gap_pct, input int lead,
                           input bit repulse, input logic [31:0] expv);
        int i;
        int g;
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        if (n == 0) exp_q.push_back('{at: cyc + 1, val: expv});
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = LEN_W'($urandom);
        if (n == 0) begin
            chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
            chk("len0_busy", 32'(bus.busy), 32'd1);
        end
        i = 0;
        g = lead;
        while (i < n) begin
            chk("in_ready", 32'(bus.in_ready), 32'd1);
            if (g > 0 || $urandom_range(0, 99) < 32'(gap_pct)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
                if (g > 0) g--;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = ops[i];
                if (repulse && i == 0) begin
                    bus.start = 1'b1;
                    bus.len   = LEN_W'($urandom);
                end
                if (i == n - 1) exp_q.push_back('{at: cyc + 1, val: expv});
                i++;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        jobs++;
    endtask

    initial begin
        int n;
        logic [31:0] prev;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_data", bus.out_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        chk("model_pin1", model_add(32'h4A36_00CA, 32'hC93C_97A8), 32'h4A06_DAE0);
        chk("model_pin2", model_add(32'h4AA4_6873, 32'h49CD_A038), 32'h4AD7_D081);
        chk("model_pin3", model_add(32'hC96A_3E8C, 32'h496E_F9C6), 32'h4697_6740);
        chk("model_pin4", model_add(32'h4921_7B24, 32'h494E_793B), 32'h49B7_FA30);
        chk("model_pin_zero", model_add(32'h3F80_0000, 32'hBF80_0000), 32'h0000_0000);

        ops[0] = 32'h4A36_00CA; ops[1] = 32'hC93C_97A8;
        run_job(2, 0, 0, 1'b0, 32'h4A06_DAE0);

        ops[0] = 32'hC8F1_5AEC;
        run_job(1, 0, 3, 1'b0, 32'hC8F1_5AEC);

        run_job(0, 0, 0, 1'b0, 32'h0000_0000);

        ops[0] = 32'h4AA4_6873; ops[1] = 32'h49CD_A038;
        run_job(2, 0, 0, 1'b1, 32'h4AD7_D081);
        ops[0] = 32'hC96A_3E8C; ops[1] = 32'h496E_F9C6;
        run_job(2, 0, 0, 1'b0, 32'h4697_6740);

        // Abort a len=3 job after two beats; rst wins over start and in_valid.
        bus.start = 1'b1;
        bus.len = LEN_W'(3);
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'h3F80_0000;
        @(negedge clk);
        bus.in_data = 32'h4000_0000;
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        bus.in_data = 32'h4040_0000;
        exp_hold = 32'h0;
        @(negedge clk);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_out_data", bus.out_data, 32'h0);
        rst = 1'b0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        ops[0] = 32'h4921_7B24; ops[1] = 32'h494E_793B;
        run_job(2, 0, 0, 1'b0, 32'h49B7_FA30);

        for (int j = 0; j < 40; j++) begin
            n = int'($urandom_range(1, 20));
            prev = 32'h0;
            for (int i = 0; i < n; i++) begin
                ops[i] = rnd_fp(prev);
                prev = ops[i];
            end
            run_job(n, 30, 0, (j % 5 == 0) && (n >= 2), ref_sum(n));
        end

        repeat (3) @(negedge clk);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("pulse_count", 32'(pulses), 32'(jobs));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
